// File: rtl/dsp48a1_op_sequencer.sv
// dsp48a1_op_sequencer: issues operand commands to one DSP48A1 slice, tracks in-flight ops and
// returns P through a credit-protected FIFO. Define DSP_SEQ_CARRY_FLAG_EN to carry CARRYOUT too.
module dsp48a1_op_sequencer #(
   parameter int LATENCY    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [1:0]  cmd_op_i,
   input  logic        cmd_last_i,
   input  logic [17:0] cmd_a_i,
   input  logic [17:0] cmd_b_i,
   input  logic [17:0] cmd_d_i,
   input  logic [47:0] cmd_c_i,
   output logic [17:0] dsp_a_o,
   output logic [17:0] dsp_b_o,
   output logic [17:0] dsp_d_o,
   output logic [47:0] dsp_c_o,
   output logic [7:0]  dsp_opmode_o,
   output logic        dsp_ce_o,
   output logic        dsp_rst_o,
   input  logic [47:0] dsp_p_i,
`ifdef DSP_SEQ_CARRY_FLAG_EN
   input  logic        dsp_carryout_i,
   output logic        res_carry_o,
`endif
   output logic        res_valid_o,
   input  logic        res_ready_i,
   output logic [47:0] res_data_o,
   output logic        err_proto_o
);
`ifdef DSP_SEQ_CARRY_FLAG_EN
   localparam int FW = 49;
`else
   localparam int FW = 48;
`endif
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(LATENCY + 2);
   localparam int TW = $clog2(LATENCY) + 1;

   typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_CHAIN} state_t;

   state_t             state_q, state_d;
   logic [TW-1:0]      fcnt_q, fcnt_d;
   logic               ce_q, err_q, err_d, iss_q, iss_emit_q;
   logic [LATENCY-1:0] vld_q, emit_q;
   logic [17:0]        a_q, b_q, d_q;
   logic [47:0]        c_q;
   logic [7:0]         opmode_q, opmode_d;
   logic [FW-1:0]      mem_q [FIFO_DEPTH];
   logic [FW-1:0]      fifo_in;
   logic [AW-1:0]      wptr_q, rptr_q;
   logic [CW-1:0]      cnt_q;
   logic [IW-1:0]      emit_cnt;
   logic               is_mac, emit_n, busy, hazard, fire, push, pop;

   always_comb begin
      is_mac = cmd_op_i == 2'b11;
      emit_n = !is_mac || cmd_last_i;
      opmode_d = cmd_op_i == 2'b00 ? 8'h01 : cmd_op_i == 2'b01 ? 8'h11 :
                 cmd_op_i == 2'b10 ? 8'h0D : state_q == S_CHAIN ? 8'h09 : 8'h01;
      emit_cnt = IW'(iss_emit_q);
      for (int i = 0; i < LATENCY; i++) emit_cnt = emit_cnt + IW'(emit_q[i]);
      busy = iss_q || vld_q != '0;
      // OPMODE is one register shared by every slice stage; only the in-chain 01->09 step may overlap
      hazard = busy && opmode_d != opmode_q && !(state_q == S_CHAIN && is_mac);
      cmd_ready_o = state_q != S_FLUSH && !hazard && int'(cnt_q) + int'(emit_cnt) < FIFO_DEPTH;
      fire = cmd_valid_i && cmd_ready_o;
      fcnt_d = state_q == S_FLUSH ? fcnt_q + TW'(1) : '0;
      err_d = err_q || (fire && state_q == S_CHAIN && !is_mac);
      state_d = state_q == S_FLUSH ? (fcnt_q == TW'(LATENCY - 1) ? S_IDLE : S_FLUSH) :
                !fire ? state_q : (is_mac && !cmd_last_i) ? S_CHAIN : S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FLUSH;
         fcnt_q     <= '0;
         ce_q       <= 1'b0;
         err_q      <= 1'b0;
         iss_q      <= 1'b0;
         iss_emit_q <= 1'b0;
         vld_q      <= '0;
         emit_q     <= '0;
         a_q        <= '0;
         b_q        <= '0;
         d_q        <= '0;
         c_q        <= '0;
         opmode_q   <= '0;
      end else begin
         state_q    <= state_d;
         fcnt_q     <= fcnt_d;
         ce_q       <= 1'b1;
         err_q      <= err_d;
         iss_q      <= fire;
         iss_emit_q <= fire && emit_n;
         vld_q      <= {vld_q[LATENCY-2:0], iss_q};
         emit_q     <= {emit_q[LATENCY-2:0], iss_emit_q};
         if (fire) begin
            a_q      <= cmd_a_i;
            b_q      <= cmd_b_i;
            d_q      <= cmd_d_i;
            c_q      <= cmd_c_i;
            opmode_q <= opmode_d;
         end
      end
   end

`ifdef DSP_SEQ_CARRY_FLAG_EN
   assign fifo_in     = {dsp_carryout_i, dsp_p_i};
   assign res_carry_o = mem_q[rptr_q][48];
`else
   assign fifo_in = dsp_p_i;
`endif
   // credits guarantee a free slot whenever an emit flag leaves the tracker
   assign push = emit_q[LATENCY-1];
   assign pop  = res_valid_o && res_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wptr_q] <= fifo_in;
            wptr_q        <= wptr_q + AW'(1);
         end
         if (pop) rptr_q <= rptr_q + AW'(1);
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
   end

   assign res_valid_o  = cnt_q != '0;
   assign res_data_o   = mem_q[rptr_q][47:0];
   assign dsp_a_o      = a_q;
   assign dsp_b_o      = b_q;
   assign dsp_d_o      = d_q;
   assign dsp_c_o      = c_q;
   assign dsp_opmode_o = opmode_q;
   assign dsp_ce_o     = ce_q;
   assign dsp_rst_o    = state_q == S_FLUSH;
   assign err_proto_o  = err_q;
endmodule

// File: tb/tb_dsp48a1_op_sequencer.sv
// tb_dsp48a1_op_sequencer: drives commands into the sequencer, models the DSP48A1 slice and
// checks results against a queue of expected values.
module tb_dsp48a1_op_sequencer;
   localparam int LAT = 4;

   typedef struct packed {
      logic [7:0]  op;
      logic [17:0] a;
      logic [17:0] b;
      logic [17:0] d;
      logic [47:0] c;
   } stg_t;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_last = 1'b0, cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic [17:0] cmd_a = '0, cmd_b = '0, cmd_d = '0;
   logic [47:0] cmd_c = '0;
   logic [17:0] dsp_a, dsp_b, dsp_d;
   logic [47:0] dsp_c, dsp_p;
   logic [7:0]  dsp_opmode;
   logic        dsp_ce, dsp_rst;
   logic        res_valid, res_ready = 1'b1, err_proto;
   logic [47:0] res_data, exp_v;
   int          tests = 0, fails = 0, cyc = 0, pops = 0, last_pop = 0;
   logic [47:0] exp_q [$];
   int          pop_cyc [$];
   stg_t        stg [3];
   logic [47:0] p_m;

   dsp48a1_op_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op), .cmd_last_i(cmd_last),
      .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_d_i(cmd_d), .cmd_c_i(cmd_c),
      .dsp_a_o(dsp_a), .dsp_b_o(dsp_b), .dsp_d_o(dsp_d), .dsp_c_o(dsp_c),
      .dsp_opmode_o(dsp_opmode), .dsp_ce_o(dsp_ce), .dsp_rst_o(dsp_rst), .dsp_p_i(dsp_p),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
      .err_proto_o(err_proto)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [47:0] slice_p(input stg_t s, input logic [47:0] p);
      logic [17:0] m2;
      logic [35:0] m;
      m2 = s.op[4] ? s.d + s.b : s.b;
      m = s.a * m2;
      return s.op == 8'h0D ? s.c + {12'd0, m} : s.op == 8'h09 ? p + {12'd0, m} : {12'd0, m};
   endfunction

   // behavioural slice: three operand stages then the P register
   always @(posedge clk) begin
      if (dsp_rst) begin
         stg[0] <= '0;
         stg[1] <= '0;
         stg[2] <= '0;
         p_m    <= '0;
      end else if (dsp_ce) begin
         stg[0] <= {dsp_opmode, dsp_a, dsp_b, dsp_d, dsp_c};
         stg[1] <= stg[0];
         stg[2] <= stg[1];
         p_m    <= slice_p(stg[2], p_m);
      end
   end
   assign dsp_p = p_m;

   always @(negedge clk) begin
      #2;
      if (rst_n && res_valid && res_ready) begin
         pops++;
         last_pop = cyc;
         pop_cyc.push_back(cyc);
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_result got %0h required none", res_data);
         end else begin
            exp_v = exp_q.pop_front();
            if (res_data !== exp_v) begin
               fails++;
               $display("FAIL result got %0h required %0h", res_data, exp_v);
            end
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic last, input logic [17:0] a,
                       input logic [17:0] b, input logic [17:0] d, input logic [47:0] c,
                       input logic [47:0] e, output int hs);
      int n;
      n = 0;
      hs = -1;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_last = last;
      cmd_a = a;
      cmd_b = b;
      cmd_d = d;
      cmd_c = c;
      #1;
      while (!cmd_ready && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!cmd_ready) begin
         tests++;
         fails++;
         $display("FAIL send_timeout got cmd_ready=0 required 1");
         cmd_valid = 1'b0;
      end else begin
         if (op != 2'b11 || last) exp_q.push_back(e);
         @(posedge clk);
         #1;
         hs = cyc;
         cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_pops(input int target);
      int n;
      n = 0;
      while (pops < target && n < 300) begin
         @(negedge clk);
         #3;
         n++;
      end
      if (pops < target) begin
         tests++;
         fails++;
         $display("FAIL wait_pops got %0d required %0d", pops, target);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      tests++;
      if (dsp_rst !== 1'b1 || res_valid !== 1'b0 || cmd_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_hold got rst=%b valid=%b ready=%b required 1 0 0", dsp_rst, res_valid, cmd_ready);
      end
      tests++;
      if (dsp_ce !== 1'b0 || err_proto !== 1'b0 || dsp_opmode !== 8'h00) begin
         fails++;
         $display("FAIL reset_outputs got ce=%b err=%b opmode=%h required 0 0 00", dsp_ce, err_proto, dsp_opmode);
      end
      rst_n = 1'b1;
      repeat (LAT - 1) @(negedge clk);
      tests++;
      if (dsp_rst !== 1'b1 || cmd_ready !== 1'b0 || dsp_ce !== 1'b1) begin
         fails++;
         $display("FAIL flush got rst=%b ready=%b ce=%b required 1 0 1", dsp_rst, cmd_ready, dsp_ce);
      end
      @(negedge clk);
      tests++;
      if (dsp_rst !== 1'b0 || cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL flush_end got rst=%b ready=%b required 0 1", dsp_rst, cmd_ready);
      end
   endtask

   task automatic test_mul();
      int hs, p0;
      p0 = pops;
      send(2'd0, 1'b0, 18'd3, 18'd5, 18'd0, 48'd0, 48'd15, hs);
      wait_pops(p0 + 1);
      tests++;
      if (last_pop - hs != LAT + 1) begin
         fails++;
         $display("FAIL mul_latency got %0d required %0d", last_pop - hs, LAT + 1);
      end
      @(negedge clk);
      #3;
      tests++;
      if (res_valid !== 1'b0) begin
         fails++;
         $display("FAIL mul_single_valid got %b required 0", res_valid);
      end
   endtask

   task automatic test_back_to_back();
      int h1, h2, h3, p0;
      p0 = pops;
      send(2'd0, 1'b0, 18'd2, 18'd7, 18'd0, 48'd0, 48'd14, h1);
      send(2'd0, 1'b0, 18'd4, 18'd4, 18'd0, 48'd0, 48'd16, h2);
      send(2'd0, 1'b0, 18'h3FFFF, 18'h3FFFF, 18'd0, 48'd0, 48'hFFFF80001, h3);
      tests++;
      if (h2 - h1 != 1 || h3 - h2 != 1) begin
         fails++;
         $display("FAIL b2b_issue got gaps %0d %0d required 1 1", h2 - h1, h3 - h2);
      end
      wait_pops(p0 + 3);
      tests++;
      if (pop_cyc.size() < p0 + 3 || pop_cyc[p0+2] - pop_cyc[p0] != 2) begin
         fails++;
         $display("FAIL b2b_bubbles got %0d results required 3 in 3 cycles", pop_cyc.size() - p0);
      end
   endtask

   task automatic test_mac_chain();
      int h1, h2, h3, h4, p0;
      p0 = pops;
      send(2'd3, 1'b0, 18'd1, 18'd2, 18'd0, 48'd0, 48'd0, h1);
      send(2'd3, 1'b0, 18'd3, 18'd4, 18'd0, 48'd0, 48'd0, h2);
      send(2'd3, 1'b1, 18'd5, 18'd6, 18'd0, 48'd0, 48'd44, h3);
      send(2'd2, 1'b0, 18'd2, 18'd3, 18'd0, 48'd100, 48'd106, h4);
      tests++;
      if (h4 - h3 < LAT + 1) begin
         fails++;
         $display("FAIL muladdc_stall got gap %0d required >= %0d", h4 - h3, LAT + 1);
      end
      wait_pops(p0 + 2);
      repeat (10) @(negedge clk);
      #3;
      tests++;
      if (pops - p0 != 2) begin
         fails++;
         $display("FAIL chain_results got %0d required 2", pops - p0);
      end
   endtask

   task automatic test_backpressure();
      int h, p0;
      p0 = pops;
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         send(2'd0, 1'b0, 18'(i + 1), 18'(i + 10), 18'd0, 48'd0, 48'((i + 1) * (i + 10)), h);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op = 2'd0;
      cmd_a = 18'd5;
      cmd_b = 18'd15;
      #1;
      tests++;
      if (cmd_ready !== 1'b0) begin
         fails++;
         $display("FAIL credit_stall got %b required 0", cmd_ready);
      end
      repeat (8) @(negedge clk);
      #1;
      tests++;
      if (cmd_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 48'd10) begin
         fails++;
         $display("FAIL fifo_full got ready=%b valid=%b data=%0h required 0 1 a", cmd_ready, res_valid, res_data);
      end
      tests++;
      if (pops != p0) begin
         fails++;
         $display("FAIL held_pops got %0d required %0d", pops, p0);
      end
      res_ready = 1'b1;
      send(2'd0, 1'b0, 18'd5, 18'd15, 18'd0, 48'd0, 48'd75, h);
      send(2'd0, 1'b0, 18'd6, 18'd16, 18'd0, 48'd0, 48'd96, h);
      wait_pops(p0 + 6);
   endtask

   task automatic test_premul_err();
      int h, p0;
      p0 = pops;
      send(2'd1, 1'b0, 18'd2, 18'd3, 18'd10, 48'd0, 48'd26, h);
      wait_pops(p0 + 1);
      send(2'd3, 1'b0, 18'd4, 18'd5, 18'd0, 48'd0, 48'd0, h);
      tests++;
      if (err_proto !== 1'b0) begin
         fails++;
         $display("FAIL err_early got %b required 0", err_proto);
      end
      send(2'd0, 1'b0, 18'd7, 18'd8, 18'd0, 48'd0, 48'd56, h);
      tests++;
      if (err_proto !== 1'b1) begin
         fails++;
         $display("FAIL err_set got %b required 1", err_proto);
      end
      wait_pops(p0 + 2);
      repeat (6) @(negedge clk);
      tests++;
      if (err_proto !== 1'b1) begin
         fails++;
         $display("FAIL err_sticky got %b required 1", err_proto);
      end
   endtask

   task automatic test_reset_mid();
      int h, p0;
      send(2'd0, 1'b0, 18'd9, 18'd9, 18'd0, 48'd0, 48'd81, h);
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      p0 = pops;
      repeat (2) @(negedge clk);
      tests++;
      if (err_proto !== 1'b0 || res_valid !== 1'b0 || dsp_rst !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid got err=%b valid=%b rst=%b required 0 0 1", err_proto, res_valid, dsp_rst);
      end
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      #3;
      tests++;
      if (pops != p0 || cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_discard got pops=%0d ready=%b required %0d 1", pops - p0, cmd_ready, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_mul();
      test_back_to_back();
      test_mac_chain();
      test_backpressure();
      test_premul_err();
      test_reset_mid();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL leftover got %0d required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
